// File: rtl/prio_arbiter8.sv
// 8-requester arbiter with a registered grant held until release, hold timeout or disable.
// Fixed priority (bit 7 highest) or round-robin, selected by RR_EN.
module prio_arbiter8 #(
  parameter int unsigned RR_EN    = 0,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       sel,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       gnt_vld,
  output logic       timeout,
  output logic       idle
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       mask_q, mask_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       owner_q, owner_d;
  logic [2:0]       last_q, last_d;
  logic             to_q, to_d;
  logic             idle_q, idle_d;

  logic [7:0] elig;
  logic [2:0] win;
  logic       hold_hit;

  assign elig     = req & ~mask_q;
  assign hold_hit = (MAX_HOLD != 0) && (cnt_q == HOLD_LIM);

  // Later loop iterations overwrite earlier ones, so the last match wins:
  // fixed mode ends on the highest index, RR mode on the one nearest below last_q.
  always_comb begin
    win = '0;
    if (RR_EN == 0) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (elig[i]) win = 3'(i);
      end
    end else begin
      for (int unsigned k = 8; k >= 1; k--) begin
        if (elig[last_q - 3'(k)]) win = last_q - 3'(k);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    to_d    = 1'b0;
    mask_d  = mask_q & req;
    idle_d  = (state_q == S_IDLE) && !((|elig) && !sel);
    if (state_q == S_IDLE) begin
      if (!sel && (|elig)) begin
        state_d = S_GRANT;
        owner_d = win;
        gnt_d   = 8'b1 << win;
        cnt_d   = CNT_W'(1);
      end
    end else begin
      if (sel || !req[owner_q] || hold_hit) begin
        state_d = S_IDLE;
        owner_d = '0;
        gnt_d   = '0;
        cnt_d   = '0;
        last_d  = owner_q;
        // Disable and release take precedence over the hold limit.
        if (!sel && req[owner_q]) begin
          to_d            = 1'b1;
          mask_d[owner_q] = 1'b1;
        end
      end else if (cnt_q != CNT_MAX) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      last_q  <= '0;
      to_q    <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      to_q    <= to_d;
      idle_q  <= idle_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_id  = owner_q;
  assign gnt_vld = (state_q == S_GRANT);
  assign timeout = to_q;
  assign idle    = idle_q;

endmodule
